sdram_device_model: RTL and testbench
=====================================

Name: sdram_device_model

Overview:
Synthesizable responder model of a single-rank 4-bank SDR SDRAM: the device end of the SDRAM command/data bus driven by our controller. Decodes {cs_n,ras_n,cas_n,we_n} commands, tracks per-bank open rows and the mode register, and stores data in a reduced on-chip array. Performs bursts with CAS latency and DQM masking, and flags protocol violations. Used in simulation benches and FPGA loopback.

Parameters:
AddrWidth, 13, DRAM address bus width
DataWidth, 16, DQ width; must be 16 (two byte lanes)
ColWidth, 10, column bits taken from addr[ColWidth-1:0] on READ/WRITE
MemRowBits, 4, low row bits kept in storage
MemColBits, 6, low column bits kept in storage (depth = 4 * 2^MemRowBits * 2^MemColBits)

Ports:
i_clk  in  1  device clock (controller's o_dram_clk domain)
i_rst_n  in  1  async active-low reset
i_dram_addr  in  AddrWidth  address bus
i_dram_ba  in  2  bank address {ba_1,ba_0}
i_dram_dq  in  DataWidth  write data from controller
i_dram_ldqm  in  1  low byte mask
i_dram_udqm  in  1  high byte mask
i_dram_we_n  in  1  write enable
i_dram_cas_n  in  1  column strobe
i_dram_ras_n  in  1  row strobe
i_dram_cs_n  in  1  chip select
i_dram_cke  in  1  clock enable
o_dram_dq  out  DataWidth  read data
o_dram_dq_oe  out  1  read data drive enable (top level builds tristate)
o_err  out  1  sticky protocol error
o_err_code  out  3  code of first error

Behaviour:
- Clock/reset: one clock, i_clk; reset asynchronous active-low on i_rst_n. Reset: o_dram_dq=0, o_dram_dq_oe=0, o_err=0, o_err_code=0, all banks idle, mode unloaded, bursts and read pipeline cleared. Storage not reset.
- cke=0: command ignored, burst counters and read pipeline frozen, outputs hold.
- Commands (cs_n,ras_n,cas_n,we_n) sampled at rising edge: 1xxx/0111 NOP; 0011 ACTIVE; 0101 READ; 0100 WRITE; 0010 PRECHARGE; 0001 AUTO REFRESH; 0000 LOAD MODE; 0110 BURST TERMINATE.
- LOAD MODE: BL=addr[2:0] (000/001/010/011 -> 1/2/4/8), CL=addr[6:4] (2 or 3). Other values: error 5, mode stays unloaded. Legal LOAD MODE with any bank open: error 2-class not raised; accepted.
- ACTIVE: open row addr on bank ba. Bank already open -> error 2, row replaced.
- READ/WRITE: column=addr[ColWidth-1:0]; A10=1 auto-precharges bank after last beat. Before mode loaded -> error 3, ignored. Bank not open -> error 1, ignored.
- Storage index = {ba, row[MemRowBits-1:0], col[MemColBits-1:0]}; upper bits dropped (aliasing intended).
- Burst: sequential; beat k column = {col[high:bits], (col[low]+k) mod BL}, i.e. wraps within BL-aligned block.
- WRITE: beat 0 data sampled at the command edge, beats 1..BL-1 on following edges. ldqm=1 blocks byte [7:0], udqm=1 blocks [15:8], per beat, same edge.
- READ at edge n: beat k driven on o_dram_dq with o_dram_dq_oe=1 after edge n+CL-1+k, valid for controller sample at edge n+CL+k. Implemented as CL-deep pipeline. Read DQM latency 2: dqm high at edge m forces that beat's byte lane to 0 (oe stays 1) for the beat sampled at m+2.
- Interrupts: new READ/WRITE truncates active burst; WRITE also cancels all pending read beats (oe low from next cycle). BURST TERMINATE stops issuing beats; already-pipelined read beats still emerge.
- PRECHARGE: A10=1 closes all banks, else bank ba. Idle bank precharge legal.
- AUTO REFRESH with any bank open -> error 4; otherwise no state change.
- Errors: o_err set on first error, o_err_code latched (1 no open row, 2 activate open bank, 3 uninitialised, 4 refresh with open bank, 5 bad mode); later errors do not overwrite; cleared only by reset.
- Reset mid-burst: burst abandoned, oe=0 asynchronously.

Test Plan:
- LOAD MODE addr=0x032 (CL3, BL4); ACTIVE ba=1 row 5; WRITE col 8 data 1111,2222,3333,4444; READ col 8 at edge n -> oe=1 and 1111..4444 sampled at edges n+3..n+6, o_err=0.
- BL4 READ col 10 -> order col10,11,8,9 (wrap within block).
- WRITE BL1 0xABCD with udqm=1 over 0x5555 -> readback 0x55CD; READ with ldqm high 2 cycles before beat -> low byte 0x00.
- READ before LOAD MODE -> o_err=1, code 3, oe never asserts; subsequent ACTIVE on open bank leaves code 3.
- CL2 BL8 READ interrupted by WRITE 3 cycles later -> oe drops next cycle, write data stored correctly.
- READ with A10=1 then READ same bank -> o_err=1, code 1; AUTO REFRESH with bank open -> code 4 in fresh run.

Source files
------------

// File: rtl/sdram_device_model.sv
// SDR SDRAM device-side responder: command decode, bank/mode
// tracking, CAS-latency read pipeline, DQM masking, error flags.
// Ports: i_clk/i_rst_n, SDRAM command/address/data inputs,
//        o_dram_dq/o_dram_dq_oe read data, o_err/o_err_code.
module sdram_device_model #(
   parameter int AddrWidth  = 13,
   parameter int DataWidth  = 16,
   parameter int ColWidth   = 10,
   parameter int MemRowBits = 4,
   parameter int MemColBits = 6
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [AddrWidth-1:0] i_dram_addr,
   input  logic [1:0]           i_dram_ba,
   input  logic [DataWidth-1:0] i_dram_dq,
   input  logic                 i_dram_ldqm,
   input  logic                 i_dram_udqm,
   input  logic                 i_dram_we_n,
   input  logic                 i_dram_cas_n,
   input  logic                 i_dram_ras_n,
   input  logic                 i_dram_cs_n,
   input  logic                 i_dram_cke,
   output logic [DataWidth-1:0] o_dram_dq,
   output logic                 o_dram_dq_oe,
   output logic                 o_err,
   output logic [2:0]           o_err_code
);

   localparam int IdxW  = 2 + MemRowBits + MemColBits;
   localparam int Depth = 1 << IdxW;
   localparam int CPad  = MemColBits - 3;

   logic [3:0] cmd;
   logic is_act, is_rd, is_wr, is_pre;
   logic is_ref, is_lmr, is_bst;

   logic [3:0]            bank_open;
   logic [MemRowBits-1:0] bank_row [4];
   logic                  mode_ld;
   logic [2:0]            bl_mask;
   logic                  cl3;

   logic                  burst_act, b_wr, b_ap;
   logic [1:0]            b_ba;
   logic [MemRowBits-1:0] b_row;
   logic [MemColBits-1:0] b_col;
   logic [2:0]            b_cnt;

   logic                 p1_v, p2_v;
   logic [DataWidth-1:0] p1_d, p2_d;
   logic [1:0]           dqm_d;
   logic [DataWidth-1:0] mem [Depth];

   logic [ColWidth-1:0]   col_full;
   logic                  rw_ok, lmr_ok, cont;
   logic                  err_hit;
   logic [2:0]            err_val;
   logic                  beat_go, beat_wr;
   logic                  beat_last, beat_ap;
   logic [1:0]            beat_ba;
   logic [MemRowBits-1:0] beat_row;
   logic [MemColBits-1:0] beat_base, beat_col;
   logic [MemColBits-1:0] cmask, kext;
   logic [2:0]            beat_k;
   logic [IdxW-1:0]       idx;
   logic                  sel_v;
   logic [DataWidth-1:0]  sel_d, rd_out;
   logic                  unused_ok;

   assign cmd = {i_dram_cs_n, i_dram_ras_n,
                 i_dram_cas_n, i_dram_we_n};
   assign col_full  = i_dram_addr[ColWidth-1:0];
   assign unused_ok = ^{i_dram_addr, col_full};

   always_comb begin
      is_act = 1'b0;
      is_rd  = 1'b0;
      is_wr  = 1'b0;
      is_pre = 1'b0;
      is_ref = 1'b0;
      is_lmr = 1'b0;
      is_bst = 1'b0;
      if (i_dram_cke) begin
         unique case (cmd)
            4'b0011: is_act = 1'b1;
            4'b0101: is_rd  = 1'b1;
            4'b0100: is_wr  = 1'b1;
            4'b0010: is_pre = 1'b1;
            4'b0001: is_ref = 1'b1;
            4'b0000: is_lmr = 1'b1;
            4'b0110: is_bst = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      rw_ok  = (is_rd | is_wr) & mode_ld
             & bank_open[i_dram_ba];
      lmr_ok = is_lmr & ~i_dram_addr[2]
             & (i_dram_addr[6:5] == 2'b01);
      err_hit = 1'b0;
      err_val = 3'd0;
      if ((is_rd | is_wr) & ~mode_ld) begin
         err_hit = 1'b1;
         err_val = 3'd3;
      end else if ((is_rd | is_wr) & ~rw_ok) begin
         err_hit = 1'b1;
         err_val = 3'd1;
      end else if (is_act & bank_open[i_dram_ba]) begin
         err_hit = 1'b1;
         err_val = 3'd2;
      end else if (is_ref & (|bank_open)) begin
         err_hit = 1'b1;
         err_val = 3'd4;
      end else if (is_lmr & ~lmr_ok) begin
         err_hit = 1'b1;
         err_val = 3'd5;
      end
   end

   // A new legal READ/WRITE or a BURST TERMINATE pre-empts the
   // running burst; otherwise the burst issues its next beat.
   always_comb begin
      cont    = burst_act & i_dram_cke & ~rw_ok & ~is_bst;
      beat_go = rw_ok | cont;
      if (rw_ok) begin
         beat_wr   = is_wr;
         beat_ba   = i_dram_ba;
         beat_row  = bank_row[i_dram_ba];
         beat_base = col_full[MemColBits-1:0];
         beat_k    = 3'd0;
         beat_ap   = i_dram_addr[10];
         beat_last = (bl_mask == 3'd0);
      end else begin
         beat_wr   = b_wr;
         beat_ba   = b_ba;
         beat_row  = b_row;
         beat_base = b_col;
         beat_k    = b_cnt;
         beat_ap   = b_ap;
         beat_last = (b_cnt == bl_mask);
      end
      cmask    = {{CPad{1'b0}}, bl_mask};
      kext     = {{CPad{1'b0}}, beat_k};
      // Wrap within the BL-aligned column block.
      beat_col = (beat_base & ~cmask)
               | ((beat_base + kext) & cmask);
      idx      = {beat_ba, beat_row, beat_col};
   end

   always_comb begin
      sel_v  = cl3 ? p2_v : p1_v;
      sel_d  = cl3 ? p2_d : p1_d;
      rd_out = sel_d;
      if (dqm_d[0]) rd_out[7:0]  = 8'h00;
      if (dqm_d[1]) rd_out[15:8] = 8'h00;
   end

   // Storage and read data path carry no reset.
   always_ff @(posedge i_clk) begin
      if (beat_go & beat_wr) begin
         if (!i_dram_ldqm)
            mem[idx][7:0] <= i_dram_dq[7:0];
         if (!i_dram_udqm)
            mem[idx][15:8] <= i_dram_dq[15:8];
      end
      if (beat_go & ~beat_wr)
         p1_d <= mem[idx];
      if (i_dram_cke)
         p2_d <= p1_d;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_dram_dq    <= '0;
         o_dram_dq_oe <= 1'b0;
         o_err        <= 1'b0;
         o_err_code   <= 3'd0;
         bank_open    <= 4'd0;
         for (int i = 0; i < 4; i++)
            bank_row[i] <= '0;
         mode_ld   <= 1'b0;
         bl_mask   <= 3'd0;
         cl3       <= 1'b0;
         burst_act <= 1'b0;
         b_wr      <= 1'b0;
         b_ap      <= 1'b0;
         b_ba      <= 2'd0;
         b_row     <= '0;
         b_col     <= '0;
         b_cnt     <= 3'd0;
         p1_v      <= 1'b0;
         p2_v      <= 1'b0;
         dqm_d     <= 2'd0;
      end else if (i_dram_cke) begin
         dqm_d        <= {i_dram_udqm, i_dram_ldqm};
         p1_v         <= beat_go & ~beat_wr;
         p2_v         <= p1_v;
         o_dram_dq_oe <= sel_v;
         o_dram_dq    <= sel_v ? rd_out : '0;
         // A WRITE flushes every pending read beat.
         if (rw_ok & is_wr) begin
            p2_v         <= 1'b0;
            o_dram_dq_oe <= 1'b0;
            o_dram_dq    <= '0;
         end
         if (lmr_ok) begin
            mode_ld <= 1'b1;
            cl3     <= i_dram_addr[4];
            bl_mask <= {i_dram_addr[1] & i_dram_addr[0],
                        i_dram_addr[1],
                        i_dram_addr[1] | i_dram_addr[0]};
         end
         if (rw_ok) begin
            b_wr      <= is_wr;
            b_ba      <= i_dram_ba;
            b_row     <= bank_row[i_dram_ba];
            b_col     <= col_full[MemColBits-1:0];
            b_ap      <= i_dram_addr[10];
            b_cnt     <= 3'd1;
            burst_act <= (bl_mask != 3'd0);
         end else if (is_bst) begin
            burst_act <= 1'b0;
         end else if (cont) begin
            b_cnt <= b_cnt + 3'd1;
            if (beat_last)
               burst_act <= 1'b0;
         end
         if (beat_go & beat_last & beat_ap)
            bank_open[beat_ba] <= 1'b0;
         if (is_act) begin
            bank_open[i_dram_ba] <= 1'b1;
            bank_row[i_dram_ba]  <=
               i_dram_addr[MemRowBits-1:0];
         end
         if (is_pre) begin
            if (i_dram_addr[10])
               bank_open <= 4'd0;
            else
               bank_open[i_dram_ba] <= 1'b0;
         end
         if (err_hit & ~o_err) begin
            o_err      <= 1'b1;
            o_err_code <= err_val;
         end
      end
   end

endmodule

// File: tb/tb_sdram_device_model.sv
// Bench for sdram_device_model: directed vector table, corner
// sequences and randomized traffic against a reference model.
module tb_sdram_device_model;

   typedef enum logic [3:0] {
      C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101,
      C_WR  = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001,
      C_LMR = 4'b0000, C_BST = 4'b0110
   } cmd_e;

   typedef struct {
      cmd_e        c;
      logic [1:0]  ba;
      logic [12:0] a;
      logic [15:0] d;
      logic [1:0]  m;
      logic        eoe;
      logic [15:0] edq;
   } vec_t;

   typedef struct {
      int e;
      bit wr;
      int idx;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [12:0] addr;
   logic [1:0]  ba;
   logic [15:0] dq_in;
   logic ldqm, udqm, we_n, cas_n, ras_n, cs_n, cke;
   logic [15:0] dq_out;
   logic oe, err;
   logic [2:0] code;

   always #5 clk = ~clk;

   sdram_device_model dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_dram_addr(addr), .i_dram_ba(ba),
      .i_dram_dq(dq_in), .i_dram_ldqm(ldqm),
      .i_dram_udqm(udqm), .i_dram_we_n(we_n),
      .i_dram_cas_n(cas_n), .i_dram_ras_n(ras_n),
      .i_dram_cs_n(cs_n), .i_dram_cke(cke),
      .o_dram_dq(dq_out), .o_dram_dq_oe(oe),
      .o_err(err), .o_err_code(code)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(string nm, logic [31:0] act,
                      logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   task automatic drive(cmd_e c, logic [1:0] b,
                        logic [12:0] a, logic [15:0] d,
                        logic [1:0] m);
      {cs_n, ras_n, cas_n, we_n} = c;
      ba = b; addr = a; dq_in = d;
      {udqm, ldqm} = m;
   endtask

   task automatic tick(cmd_e c, logic [1:0] b = 2'd0,
                       logic [12:0] a = 13'd0,
                       logic [15:0] d = 16'd0,
                       logic [1:0] m = 2'd0);
      drive(c, b, a, d, m);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(C_NOP, 0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- reference model ----------------
   int          cyc;
   bit          m_ld;
   int          m_bl, m_cl;
   bit          m_open [4];
   int          m_row [4];
   beat_t       plan [$];
   logic [15:0] mmem [4096];
   logic [15:0] mknown [4096];
   bit          exp_oe [2048];
   logic [15:0] exp_dq [2048];
   logic [15:0] exp_km [2048];
   logic [1:0]  dqm_hist [2048];

   function automatic int midx(int b, int r, int c);
      return b * 1024 + (r % 16) * 64 + (c % 64);
   endfunction

   task automatic model_clear();
      cyc = 0; m_ld = 0; m_bl = 1; m_cl = 2;
      plan.delete();
      for (int i = 0; i < 4; i++) m_open[i] = 0;
      for (int i = 0; i < 2048; i++) begin
         exp_oe[i] = 0; dqm_hist[i] = 2'b00;
      end
   endtask

   task automatic model_edge(cmd_e c, logic [1:0] b,
                             logic [12:0] a, logic [15:0] d,
                             logic [1:0] m);
      int base, col, t;
      beat_t bt;
      dqm_hist[cyc] = m;
      case (c)
         C_LMR:
            if (a[2] == 0 && (a[6:4] == 2 || a[6:4] == 3)) begin
               m_ld = 1; m_bl = 1 << a[1:0]; m_cl = a[6:4];
            end
         C_ACT: begin m_open[b] = 1; m_row[b] = a; end
         C_PRE:
            if (a[10]) for (int i = 0; i < 4; i++) m_open[i] = 0;
            else m_open[b] = 0;
         C_BST: plan.delete();
         C_RD, C_WR:
            if (m_ld && m_open[b]) begin
               plan.delete();
               base = a[9:0];
               for (int k = 0; k < m_bl; k++) begin
                  col = base - base % m_bl
                      + (base % m_bl + k) % m_bl;
                  plan.push_back('{cyc + k, c == C_WR,
                                   midx(b, m_row[b], col)});
               end
               if (c == C_WR)
                  for (int i = cyc; i < 2048; i++) exp_oe[i] = 0;
            end
         default: ;
      endcase
      if (plan.size() > 0 && plan[0].e == cyc) begin
         bt = plan.pop_front();
         if (bt.wr) begin
            if (!m[0]) begin
               mmem[bt.idx][7:0] = d[7:0];
               mknown[bt.idx][7:0] = 8'hff;
            end
            if (!m[1]) begin
               mmem[bt.idx][15:8] = d[15:8];
               mknown[bt.idx][15:8] = 8'hff;
            end
         end else begin
            t = cyc + m_cl - 1;
            exp_oe[t] = 1;
            exp_dq[t] = mmem[bt.idx];
            exp_km[t] = mknown[bt.idx];
         end
      end
   endtask

   task automatic step(cmd_e c, logic [1:0] b,
                       logic [12:0] a, logic [15:0] d,
                       logic [1:0] m);
      logic [15:0] mk, e, k;
      drive(c, b, a, d, m);
      @(posedge clk);
      cyc++;
      model_edge(c, b, a, d, m);
      #1;
      chk("rnd_oe", oe, exp_oe[cyc]);
      if (exp_oe[cyc]) begin
         mk = {{8{dqm_hist[cyc-1][1]}}, {8{dqm_hist[cyc-1][0]}}};
         e  = exp_dq[cyc] & ~mk;
         k  = exp_km[cyc] | mk;
         chk("rnd_rdata", dq_out & k, e & k);
      end
   endtask

   task automatic run_random(int n);
      int r, blc, cl;
      cmd_e c;
      logic [9:0] col;
      logic [1:0] m;
      do_reset();
      model_clear();
      blc = $urandom_range(0, 3);
      cl  = $urandom_range(2, 3);
      step(C_LMR, 0, {6'd0, 3'(cl), 2'd0, 2'(blc)}, 0, 0);
      for (int b = 0; b < 4; b++)
         step(C_ACT, 2'(b), 13'($urandom), 0, 0);
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 99);
         if (r < 40)      c = C_NOP;
         else if (r < 65) c = C_RD;
         else if (r < 92) c = C_WR;
         else             c = C_BST;
         col = 10'(($urandom & 32'h3c0) | $urandom_range(0, 15));
         m = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         step(c, 2'($urandom), {2'($urandom), 1'b0, col},
              16'($urandom), m);
      end
      for (int i = 0; i < 12; i++)
         step(C_NOP, 0, 0, 16'($urandom), 0);
      chk("rnd_no_err", err, 0);
   endtask

   // ---------------- directed vectors ----------------
   vec_t tv [29];
   bit   seen;

   initial begin
      for (int i = 0; i < 4096; i++) mknown[i] = 16'h0;
      tv[0]  = '{C_LMR, 0, 13'h032, 16'h0000, 2'b00, 0, 16'h0};
      tv[1]  = '{C_ACT, 1, 13'h005, 16'h0000, 2'b00, 0, 16'h0};
      tv[2]  = '{C_WR,  1, 13'h008, 16'h1111, 2'b00, 0, 16'h0};
      tv[3]  = '{C_NOP, 0, 13'h000, 16'h2222, 2'b00, 0, 16'h0};
      tv[4]  = '{C_NOP, 0, 13'h000, 16'h3333, 2'b00, 0, 16'h0};
      tv[5]  = '{C_NOP, 0, 13'h000, 16'h4444, 2'b00, 0, 16'h0};
      tv[6]  = '{C_RD,  1, 13'h008, 16'h0000, 2'b00, 0, 16'h0};
      tv[7]  = '{C_NOP, 0, 13'h000, 16'h0000, 2'b00, 0, 16'h0};
      tv[8]  = '{C_NOP, 0, 13'h000, 16'h0000, 2'b00, 1, 16'h1111};
      tv[9]  = '{C_NOP, 0, 13'h000, 16'h0000, 2'b00, 1, 16'h2222};
      tv[10] = '{C_NOP, 0, 13'h000, 16'h0000, 2'b00, 1, 16'h3333};
      tv[11] = '{C_NOP, 0, 13'h000, 16'h0000, 2'b00, 1, 16'h4444};
      tv[12] = '{C_RD,  1, 13'h00a, 16'h0000, 2'b00, 0, 16'h0};
      tv[13] = '{C_NOP, 0, 13'h000, 16'h0000, 2'b00, 0, 16'h0};
      tv[14] = '{C_NOP, 0, 13'h000, 16'h0000, 2'b00, 1, 16'h3333};
      tv[15] = '{C_NOP, 0, 13'h000, 16'h0000, 2'b00, 1, 16'h4444};
      tv[16] = '{C_NOP, 0, 13'h000, 16'h0000, 2'b00, 1, 16'h1111};
      tv[17] = '{C_NOP, 0, 13'h000, 16'h0000, 2'b00, 1, 16'h2222};
      tv[18] = '{C_NOP, 0, 13'h000, 16'h0000, 2'b00, 0, 16'h0};
      tv[19] = '{C_LMR, 0, 13'h030, 16'h0000, 2'b00, 0, 16'h0};
      tv[20] = '{C_WR,  1, 13'h014, 16'h5555, 2'b00, 0, 16'h0};
      tv[21] = '{C_WR,  1, 13'h014, 16'habcd, 2'b10, 0, 16'h0};
      tv[22] = '{C_RD,  1, 13'h014, 16'h0000, 2'b00, 0, 16'h0};
      tv[23] = '{C_NOP, 0, 13'h000, 16'h0000, 2'b00, 0, 16'h0};
      tv[24] = '{C_NOP, 0, 13'h000, 16'h0000, 2'b00, 1, 16'h55cd};
      tv[25] = '{C_RD,  1, 13'h014, 16'h0000, 2'b00, 0, 16'h0};
      tv[26] = '{C_NOP, 0, 13'h000, 16'h0000, 2'b01, 0, 16'h0};
      tv[27] = '{C_NOP, 0, 13'h000, 16'h0000, 2'b00, 1, 16'h5500};
      tv[28] = '{C_NOP, 0, 13'h000, 16'h0000, 2'b00, 0, 16'h0};

      cke = 1'b1;
      drive(C_NOP, 0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_oe", oe, 0);
      chk("rst_dq", dq_out, 0);
      chk("rst_err", err, 0);
      chk("rst_code", code, 0);
      rst_n = 1'b1;

      // READ before LOAD MODE
      tick(C_RD, 0, 13'h000);
      chk("uninit_err", err, 1);
      chk("uninit_code", code, 3);
      seen = 0;
      repeat (6) begin tick(C_NOP); if (oe) seen = 1; end
      chk("uninit_no_oe", seen, 0);
      tick(C_ACT, 0, 13'h001);
      tick(C_ACT, 0, 13'h002);
      chk("code_sticky", code, 3);

      // vector table
      do_reset();
      for (int i = 0; i < 29; i++) begin
         tick(tv[i].c, tv[i].ba, tv[i].a, tv[i].d, tv[i].m);
         chk($sformatf("tbl_oe_%0d", i), oe, tv[i].eoe);
         if (tv[i].eoe)
            chk($sformatf("tbl_dq_%0d", i), dq_out, tv[i].edq);
      end
      chk("tbl_err", err, 0);

      // reset during a read burst
      tick(C_RD, 1, 13'h008);
      tick(C_NOP);
      tick(C_NOP);
      chk("pre_rst_data", {oe, dq_out}, {1'b1, 16'h1111});
      rst_n = 1'b0;
      #1;
      chk("async_rst_oe", oe, 0);
      chk("async_rst_dq", dq_out, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // CL2 BL8 read cut by a WRITE
      do_reset();
      tick(C_LMR, 0, 13'h023);
      tick(C_ACT, 2, 13'h007);
      for (int k = 0; k < 8; k++)
         tick(k == 0 ? C_WR : C_NOP, 2, 13'h000, 16'(16'h0100 + k));
      tick(C_NOP);
      tick(C_RD, 2, 13'h000);
      chk("cl2_first_oe", oe, 0);
      tick(C_NOP);
      chk("cl2_beat0", {oe, dq_out}, {1'b1, 16'h0100});
      tick(C_NOP);
      chk("cl2_beat1", {oe, dq_out}, {1'b1, 16'h0101});
      tick(C_WR, 2, 13'h010, 16'h0200);
      chk("intr_oe_drop", oe, 0);
      seen = 0;
      for (int k = 1; k < 8; k++) begin
         tick(C_NOP, 0, 0, 16'(16'h0200 + k));
         if (oe) seen = 1;
      end
      chk("intr_oe_stays_low", seen, 0);
      tick(C_NOP);
      tick(C_RD, 2, 13'h010);
      for (int k = 0; k < 8; k++) begin
         tick(C_NOP);
         chk($sformatf("intr_wdata_%0d", k), {oe, dq_out},
             {1'b1, 16'(16'h0200 + k)});
      end
      chk("intr_err", err, 0);

      // auto-precharge then READ on the closed bank
      do_reset();
      tick(C_LMR, 0, 13'h021);
      tick(C_ACT, 3, 13'h001);
      tick(C_RD, 3, 13'h400);
      repeat (3) tick(C_NOP);
      chk("ap_no_err_yet", err, 0);
      tick(C_RD, 3, 13'h000);
      chk("ap_err", err, 1);
      chk("ap_code", code, 1);

      // refresh rules
      do_reset();
      tick(C_LMR, 0, 13'h032);
      tick(C_REF);
      chk("ref_idle_ok", err, 0);
      tick(C_ACT, 0, 13'h003);
      tick(C_REF);
      chk("ref_open_err", err, 1);
      chk("ref_open_code", code, 4);

      // illegal CAS latency
      do_reset();
      tick(C_LMR, 0, 13'h052);
      chk("badmode_code", code, 5);
      tick(C_ACT, 0, 13'h000);
      tick(C_RD, 0, 13'h000);
      seen = 0;
      repeat (5) begin tick(C_NOP); if (oe) seen = 1; end
      chk("badmode_no_oe", seen, 0);
      chk("badmode_sticky", code, 5);

      repeat (3) run_random(600);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
